// File: rtl/j_dsp_run_ctrl.sv
// Run/single-step sequencer for the Jerry DSP instruction pipeline.
// Define DSP_STEP_COUNT_EN to add the 16-bit issued-instruction counter.
module j_dsp_run_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        single_step,
  input  logic        single_go,
  input  logic        instr_issue,
  input  logic        pipe_idle,
  output logic        run,
  output logic        single_stop,
  output logic        halted,
`ifdef DSP_STEP_COUNT_EN
  output logic [15:0] step_count,
`endif
  output logic        step_done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN        = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_ISSUE = 3'd3,
    DRAIN      = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   run_q, run_d;
  logic   single_stop_q, single_stop_d;
  logic   halted_q, halted_d;
  logic   step_done_q, step_done_d;

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = single_step ? STEP_WAIT : RUN;
      end
      RUN: begin
        if (!go)             state_d = DRAIN;
        else if (single_step) state_d = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (!go)              state_d = DRAIN;
        else if (!single_step) state_d = RUN;
        else if (single_go)   state_d = STEP_ISSUE;
      end
      STEP_ISSUE: begin
        if (!go) begin
          state_d = DRAIN;
        end else if (instr_issue) begin
          state_d     = single_step ? STEP_WAIT : RUN;
          step_done_d = 1'b1;
        end
      end
      DRAIN: begin
        if (pipe_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they land with it.
    run_d         = (state_d == RUN) || (state_d == STEP_ISSUE);
    single_stop_d = (state_d == STEP_WAIT);
    halted_d      = (state_d == IDLE);
  end

`ifdef DSP_STEP_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d != IDLE) cnt_d = 16'd0;
    else if (run_q && instr_issue)          cnt_d = cnt_q + 16'd1;
  end

  assign step_count = cnt_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      run_q         <= 1'b0;
      single_stop_q <= 1'b0;
      halted_q      <= 1'b1;
      step_done_q   <= 1'b0;
`ifdef DSP_STEP_COUNT_EN
      cnt_q         <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      single_stop_q <= single_stop_d;
      halted_q      <= halted_d;
      step_done_q   <= step_done_d;
`ifdef DSP_STEP_COUNT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign run         = run_q;
  assign single_stop = single_stop_q;
  assign halted      = halted_q;
  assign step_done   = step_done_q;

endmodule
